// File: rtl/mem_wb_stage_pkg.sv
// Shared widths, MEM/WB latch layout and address-legality helper for the MEM/WB stage.
package mem_wb_stage_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  reg_idx_t;

  typedef struct packed {
    word_t    alu_result;
    word_t    mdata;
    logic     m2reg;
    logic     wreg;
    reg_idx_t rn;
  } mem_wb_t;

  // Word-aligned and inside the 4*2^aw byte window starting at address 0.
  function automatic logic addr_valid(input word_t addr, input int unsigned aw);
    return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == '0);
  endfunction

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// Word-organised data memory: synchronous write, asynchronous read, asynchronous clear.
module mem_wb_stage_data_mem
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t mem_q [DEPTH];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read sees pre-edge contents, so a same-cycle store is not bypassed.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage data access plus the MEM/WB pipeline latch, forwarding value and sticky fault flag.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     clrn,
  input  word_t    mem_Alu_Result,
  input  word_t    mem_rb,
  input  logic     mem_wmem,
  input  logic     mem_m2reg,
  input  logic     mem_wreg,
  input  reg_idx_t mem_rn,
  output word_t    wb_Alu_Result,
  output word_t    wb_mdata,
  output logic     wb_m2reg,
  output logic     wb_wreg,
  output reg_idx_t wb_rn,
  output word_t    wb_data,
  output word_t    fwd_mem_data,
  output logic     addr_fault
);

  logic          access_valid;
  logic          access_req;
  logic          mem_we;
  logic [AW-1:0] word_idx;
  word_t         raw_rdata;
  word_t         rd_data;

  mem_wb_t wb_q, wb_d;
  logic    fault_q, fault_d;

  assign access_valid = addr_valid(mem_Alu_Result, AW);
  assign word_idx     = mem_Alu_Result[AW+1:2];
  assign access_req   = mem_wmem | mem_m2reg;
  // A store wins when both wmem and m2reg are set; the read path still runs.
  assign mem_we       = mem_wmem & access_valid;

  mem_wb_stage_data_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_data_mem (
    .clk   (clk),
    .clrn  (clrn),
    .we    (mem_we),
    .waddr (word_idx),
    .wdata (mem_rb),
    .raddr (word_idx),
    .rdata (raw_rdata)
  );

  always_comb begin
    rd_data      = access_valid ? raw_rdata : '0;
    fwd_mem_data = mem_m2reg ? rd_data : mem_Alu_Result;
  end

  always_comb begin
    wb_d            = wb_q;
    wb_d.alu_result = mem_Alu_Result;
    wb_d.mdata      = rd_data;
    wb_d.m2reg      = mem_m2reg;
    wb_d.rn         = mem_rn;
    // A faulting load must not commit garbage to the register file.
    wb_d.wreg       = mem_wreg & ~(mem_m2reg & ~access_valid);
    fault_d         = fault_q | (access_req & ~access_valid);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wb_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      wb_q    <= wb_d;
      fault_q <= fault_d;
    end
  end

  assign wb_Alu_Result = wb_q.alu_result;
  assign wb_mdata      = wb_q.mdata;
  assign wb_m2reg      = wb_q.m2reg;
  assign wb_wreg       = wb_q.wreg;
  assign wb_rn         = wb_q.rn;
  assign wb_data       = wb_q.m2reg ? wb_q.mdata : wb_q.alu_result;
  assign addr_fault    = fault_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a behavioural memory/latch model and per-cycle compare.
module tb_mem_wb_stage;

  localparam int unsigned DEPTH = 32;

  logic        clk;
  logic        clrn;
  logic [31:0] mem_Alu_Result;
  logic [31:0] mem_rb;
  logic        mem_wmem;
  logic        mem_m2reg;
  logic        mem_wreg;
  logic [4:0]  mem_rn;
  logic [31:0] wb_Alu_Result;
  logic [31:0] wb_mdata;
  logic        wb_m2reg;
  logic        wb_wreg;
  logic [4:0]  wb_rn;
  logic [31:0] wb_data;
  logic [31:0] fwd_mem_data;
  logic        addr_fault;

  mem_wb_stage #(
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .clrn           (clrn),
    .mem_Alu_Result (mem_Alu_Result),
    .mem_rb         (mem_rb),
    .mem_wmem       (mem_wmem),
    .mem_m2reg      (mem_m2reg),
    .mem_wreg       (mem_wreg),
    .mem_rn         (mem_rn),
    .wb_Alu_Result  (wb_Alu_Result),
    .wb_mdata       (wb_mdata),
    .wb_m2reg       (wb_m2reg),
    .wb_wreg        (wb_wreg),
    .wb_rn          (wb_rn),
    .wb_data        (wb_data),
    .fwd_mem_data   (fwd_mem_data),
    .addr_fault     (addr_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_alu, exp_mdata, exp_fwd;
  logic        exp_m2, exp_wreg, exp_fault;
  logic [4:0]  exp_rn;
  bit          cmp_en;

  int n_vec;
  int n_miss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'(DEPTH * 4));
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (legal(a)) return model_mem[a / 4];
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("wb_Alu_Result", wb_Alu_Result, exp_alu);
      check("wb_mdata", wb_mdata, exp_mdata);
      check("wb_m2reg", {31'b0, wb_m2reg}, {31'b0, exp_m2});
      check("wb_wreg", {31'b0, wb_wreg}, {31'b0, exp_wreg});
      check("wb_rn", {27'b0, wb_rn}, {27'b0, exp_rn});
      check("wb_data", wb_data, exp_m2 ? exp_mdata : exp_alu);
      check("fwd_mem_data", fwd_mem_data, exp_fwd);
      check("addr_fault", {31'b0, addr_fault}, {31'b0, exp_fault});
    end
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    exp_alu = 32'h0; exp_mdata = 32'h0; exp_fwd = 32'h0;
    exp_m2 = 1'b0; exp_wreg = 1'b0; exp_fault = 1'b0; exp_rn = 5'h0;
  endtask

  task automatic assert_reset();
    clrn = 1'b0;
    mem_Alu_Result = 32'h0; mem_rb = 32'h0;
    mem_wmem = 1'b0; mem_m2reg = 1'b0; mem_wreg = 1'b0; mem_rn = 5'h0;
    model_clear();
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #1 clrn = 1'b1;
  endtask

  task automatic set_in(input logic [31:0] a, input logic [31:0] rb,
                        input logic wm, input logic m2, input logic wr, input logic [4:0] rn);
    mem_Alu_Result = a; mem_rb = rb;
    mem_wmem = wm; mem_m2reg = m2; mem_wreg = wr; mem_rn = rn;
    exp_fwd = m2 ? mread(a) : a;
  endtask

  // Advance one edge and apply the MEM/WB rules to the model.
  task automatic tick();
    logic [31:0] a;
    a = mem_Alu_Result;
    @(posedge clk);
    exp_alu   = a;
    exp_mdata = mread(a);
    exp_m2    = mem_m2reg;
    exp_rn    = mem_rn;
    exp_wreg  = mem_wreg && !(mem_m2reg && !legal(a));
    if ((mem_wmem || mem_m2reg) && !legal(a)) exp_fault = 1'b1;
    if (mem_wmem && legal(a)) model_mem[a / 4] = mem_rb;
    #1;
    exp_fwd = mem_m2reg ? mread(a) : a;
  endtask

  task automatic cycle(input logic [31:0] a, input logic [31:0] rb,
                       input logic wm, input logic m2, input logic wr, input logic [4:0] rn);
    set_in(a, rb, wm, m2, wr, rn);
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    cmp_en = 1'b1;
    assert_reset();
    release_reset();

    // Reset state
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_addr_fault", {31'b0, addr_fault}, 32'h0);
    set_in(32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd1);
    #1 check("rst_read_0x00", fwd_mem_data, 32'h0);
    tick();
    set_in(32'h7C, 32'h0, 1'b0, 1'b1, 1'b1, 5'd2);
    #1 check("rst_read_0x7C", fwd_mem_data, 32'h0);
    tick();

    // Store then load
    cycle(32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 5'd0);
    cycle(32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 5'd5);
    check("ld_wb_data", wb_data, 32'hDEADBEEF);
    check("ld_wb_rn", {27'b0, wb_rn}, 32'd5);
    check("ld_wb_wreg", {31'b0, wb_wreg}, 32'd1);

    // ALU pass-through with an address that would be illegal for memory
    cycle(32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 5'd31);
    check("alu_wb_data", wb_data, 32'h12345678);
    check("alu_no_fault", {31'b0, addr_fault}, 32'd0);

    // Forwarding before the edge
    cycle(32'h20, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 5'd0);
    set_in(32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 5'd7);
    #1 check("fwd_load", fwd_mem_data, 32'hA5A5A5A5);
    tick();

    // Store and m2reg together: load data is the pre-store word
    cycle(32'h20, 32'h11112222, 1'b1, 1'b1, 1'b1, 5'd8);
    check("st_m2_mdata", wb_mdata, 32'hA5A5A5A5);
    check("st_m2_m2reg", {31'b0, wb_m2reg}, 32'd1);
    cycle(32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 5'd9);
    check("st_m2_after", wb_data, 32'h11112222);

    // Misaligned load
    cycle(32'h13, 32'h0, 1'b0, 1'b1, 1'b1, 5'd3);
    check("mis_wb_wreg", {31'b0, wb_wreg}, 32'd0);
    check("mis_wb_mdata", wb_mdata, 32'h0);
    check("mis_fault", {31'b0, addr_fault}, 32'd1);

    // Out-of-range store must not alias onto word 0
    cycle(32'h0, 32'hCAFE0000, 1'b1, 1'b0, 1'b0, 5'd0);
    cycle(32'h80, 32'hBAD0BAD0, 1'b1, 1'b0, 1'b0, 5'd0);
    cycle(32'h22, 32'hBAD1BAD1, 1'b1, 1'b0, 1'b0, 5'd0);
    cycle(32'h7C, 32'h0F0F1234, 1'b1, 1'b0, 1'b0, 5'd0);
    cycle(32'h40, 32'h600DF00D, 1'b1, 1'b0, 1'b1, 5'd4);
    cycle(32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd10);
    check("oor_word0", wb_data, 32'hCAFE0000);
    check("oor_fault_sticky", {31'b0, addr_fault}, 32'd1);

    // Sweep every word against the model
    for (int w = 0; w < DEPTH; w++) begin
      cycle(32'(w * 4), 32'h0, 1'b0, 1'b1, 1'b1, 5'(w));
    end

    // Asynchronous reset right after a store, between edges
    cycle(32'h4, 32'h55, 1'b1, 1'b0, 1'b1, 5'd12);
    #1 assert_reset();
    #1;
    check("async_wb_Alu_Result", wb_Alu_Result, 32'h0);
    check("async_wb_data", wb_data, 32'h0);
    check("async_fault", {31'b0, addr_fault}, 32'h0);
    release_reset();
    cycle(32'h4, 32'h0, 1'b0, 1'b1, 1'b1, 5'd13);
    check("post_rst_load", wb_data, 32'h0);
    check("post_rst_m2reg", {31'b0, wb_m2reg}, 32'd1);
    cycle(32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 5'd14);
    cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);

    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Consumer end of the EXE/MEM pipeline latch in the 5-stage pipelined CPU. Takes the latched ALU result, store data and control bits, and performs the data-memory access. It then latches the result into the MEM/WB register that feeds register-file write-back. It also exposes MEM-stage forwarding values and a sticky address-fault flag.

Parameters:
DEPTH, 32, number of 32-bit words in the data memory (power of two, 4..1024)
AW, log2(DEPTH), word-address width derived from DEPTH

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
clrn  input  1  asynchronous active-low reset
mem_Alu_Result  input  32  byte address for loads/stores, or ALU result for write-back
mem_rb  input  32  store data
mem_wmem  input  1  store enable
mem_m2reg  input  1  1 = write-back value comes from memory (load)
mem_wreg  input  1  register-file write enable
mem_rn  input  5  destination register number
wb_Alu_Result  output  32  latched ALU result
wb_mdata  output  32  latched load data
wb_m2reg  output  1  latched m2reg
wb_wreg  output  1  latched wreg, forced 0 on faulting load
wb_rn  output  5  latched destination register
wb_data  output  32  write-back value: wb_mdata if wb_m2reg, else wb_Alu_Result
fwd_mem_data  output  32  MEM-stage forward value: load data if mem_m2reg, else mem_Alu_Result
addr_fault  output  1  sticky: misaligned or out-of-range access seen since reset

Behaviour:
- Reset (clrn=0, asynchronous): all wb_* registers 0, wb_data 0, addr_fault 0, every memory word cleared to 0. Reset mid-store: the store is lost and the word reads 0.
- Word index = mem_Alu_Result[AW+1:2].
- Access is valid iff mem_Alu_Result[1:0]==0 and mem_Alu_Result[31:AW+2]==0.
- Read is combinational from the array at the word index; fwd_mem_data follows within the same cycle.
- Invalid load: read data = 0.
- Store: on the rising clk edge when mem_wmem=1, the access is valid and clrn=1, mem_rb is written to the word. An invalid store writes nothing.
- Same-cycle store and read of the same word: the read returns the old contents. The new value is visible from the next cycle, so a load in the following cycle sees the stored data with no bypass needed.
- MEM/WB latch, every rising edge with clrn=1:
  - wb_Alu_Result <= mem_Alu_Result
  - wb_mdata <= read data
  - wb_m2reg <= mem_m2reg
  - wb_rn <= mem_rn
  - wb_wreg <= mem_wreg & ~(mem_m2reg & invalid)
- Latency: one cycle from MEM inputs to wb_* outputs. wb_data is combinational from the latched fields.
- addr_fault is set on any edge where (mem_wmem | mem_m2reg) and the access is invalid. Only reset clears it.
- Control decode of mem_wmem and mem_m2reg both 1: treat as a store. wb_m2reg still latches 1, and load data is the pre-store word.
- No stall or flush inputs; a bubble is represented by mem_wreg=mem_wmem=0 upstream.

Decomposition:
- Shared package constants: WORD_W=32, REG_W=5.
- Natural sub-module: data_mem (synchronous write, asynchronous read, async clear, DEPTH/AW parameters). The MEM/WB latch and fault logic stay in the top module.

Test Plan:
- Reset check: hold clrn=0, then release. All wb_* and addr_fault are 0, and reading address 0x0 and 0x7C gives 0.
- Store then load: store 0xDEADBEEF at 0x10 (mem_wmem=1), then next cycle load 0x10 with mem_m2reg=1, mem_wreg=1, mem_rn=5. One cycle later wb_data=0xDEADBEEF, wb_rn=5, wb_wreg=1.
- ALU pass-through: mem_Alu_Result=0x12345678, mem_m2reg=0, mem_wreg=1, mem_rn=31. Next cycle wb_data=0x12345678, memory unchanged, addr_fault=0.
- Forwarding: word 0x20 preloaded with 0xA5A5A5A5, load 0x20. fwd_mem_data=0xA5A5A5A5 in the same cycle, before the edge.
- Faults:
  - Load 0x13 with wreg=1: wb_wreg=0, wb_mdata=0, addr_fault=1.
  - Store to 0x80 with DEPTH=32: no word is modified, addr_fault stays 1 until clrn pulses.
- Async reset mid-stream: assert clrn=0 between edges right after storing 0x55 at 0x4. Outputs go to 0 immediately, and after release a load of 0x4 returns 0.
